// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared constants, error codes and FSM state encoding for the UART command frame controller.
// UART_DATA_LENGTH falls back to 8 when the surrounding build does not define it.
`ifndef UART_DATA_LENGTH
`define UART_DATA_LENGTH 8
`endif

package uart_cmd_ctrl_pkg;

    localparam logic [7:0] UART_CMD_SYNC = 8'hA5;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_LEN  = 3'd1;
    localparam logic [2:0] ERR_CHK  = 3'd2;
    localparam logic [2:0] ERR_OVR  = 3'd3;
    localparam logic [2:0] ERR_TMO  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_LEN    = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_COMMIT = 3'd5
    } cmd_state_e;

endpackage

// File: rtl/uart_cmd_buf.sv
// Payload buffer for uart_cmd_ctrl: MAX_LEN x 8 register file, one synchronous write port,
// one asynchronous read port. Contents are data only and are never reset.
module uart_cmd_buf
    import uart_cmd_ctrl_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [7:0]       wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [7:0]       rdata_o
);

    logic [7:0] mem_q [MAX_LEN];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command frame controller behind uart_rx: sync hunt, ADDR/LEN/payload/CHK parse, commit as a write burst.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl
    import uart_cmd_ctrl_pkg::*;
#(
    parameter int DATA_LENGTH    = `UART_DATA_LENGTH,
    parameter int ADDR_WIDTH     = 8,
    parameter int MAX_LEN        = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [DATA_LENGTH-1:0] rx_data_i,
    input  logic                   rx_data_i_v,
    output logic [ADDR_WIDTH-1:0]  wr_addr_o,
    output logic [7:0]             wr_data_o,
    output logic                   wr_o_v,
    input  logic                   wr_rdy_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [2:0]             err_code_o
);

    localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    cmd_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            sum_q, sum_d;
    logic                  err_q, err_d;
    logic [2:0]            code_q, code_d;
    logic                  done_q, done_d;

    logic [7:0]            rx_byte;
    logic                  buf_we;
    logic [7:0]            buf_rdata;
    logic                  commit;
    logic                  last_idx;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    assign rx_byte  = rx_data_i[7:0];
    assign commit   = (state_q == ST_COMMIT);
    assign last_idx = (cnt_q == len_q - 8'd1);

    uart_cmd_buf #(
        .MAX_LEN (MAX_LEN),
        .IDX_W   (IDX_W)
    ) u_buf (
        .clk_i   (clk_i),
        .we_i    (buf_we),
        .waddr_i (cnt_q[IDX_W-1:0]),
        .wdata_i (rx_byte),
        .raddr_i (cnt_q[IDX_W-1:0]),
        .rdata_o (buf_rdata)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        code_d  = code_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        buf_we  = 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
        tmo_d   = '0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (rx_data_i_v && rx_byte == UART_CMD_SYNC) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (rx_data_i_v) begin
                    addr_d  = ADDR_WIDTH'(rx_byte);
                    sum_d   = rx_byte;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_data_i_v) begin
                    if (rx_byte == 8'd0 || rx_byte > MAX_LEN_B) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = ST_IDLE;
                    end else begin
                        len_d   = rx_byte;
                        cnt_d   = 8'd0;
                        sum_d   = sum_q + rx_byte;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_data_i_v) begin
                    buf_we = 1'b1;
                    sum_d  = sum_q + rx_byte;
                    cnt_d  = cnt_q + 8'd1;
                    if (last_idx) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (rx_data_i_v) begin
                    if (rx_byte == sum_q) begin
                        cnt_d   = 8'd0;
                        state_d = ST_COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CHK;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_COMMIT: begin
                // A byte arriving mid-commit is dropped; the burst itself carries on untouched.
                if (rx_data_i_v) begin
                    err_d  = 1'b1;
                    code_d = ERR_OVR;
                end
                if (wr_rdy_i) begin
                    cnt_d = cnt_q + 8'd1;
                    if (last_idx) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef UART_CMD_TIMEOUT_EN
        // Stall watchdog only while a frame is being parsed.
        if (state_q inside {ST_ADDR, ST_LEN, ST_DATA, ST_CHK} && !rx_data_i_v) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                err_d   = 1'b1;
                code_d  = ERR_TMO;
                state_d = ST_IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= 8'd0;
            cnt_q   <= 8'd0;
            sum_q   <= 8'd0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
            code_q  <= code_d;
            done_q  <= done_d;
        end
    end

`ifdef UART_CMD_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // Outputs are gated by COMMIT so they read zero outside a burst, including out of reset.
    assign wr_o_v     = commit;
    assign wr_addr_o  = commit ? addr_q + ADDR_WIDTH'(cnt_q) : '0;
    assign wr_data_o  = commit ? buf_rdata : 8'd0;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = code_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed self-checking bench for uart_cmd_ctrl; the timeout scenario runs when UART_CMD_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_uart_cmd_ctrl;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TMO = 50;
`else
    localparam int TMO = 100000;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_v;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_v;
    logic       wr_rdy;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] err_code;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [15:0] wq[$];

    uart_cmd_ctrl #(
        .DATA_LENGTH    (8),
        .ADDR_WIDTH     (8),
        .MAX_LEN        (16),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_data_i   (rx_data),
        .rx_data_i_v (rx_v),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data),
        .wr_o_v      (wr_v),
        .wr_rdy_i    (wr_rdy),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .err_code_o  (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_v && wr_rdy) wq.push_back({wr_addr, wr_data});
            if (done) done_cnt++;
            if (err) err_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_v = 1'b1;
        @(posedge clk); #1;
        rx_v = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; rx_v = 1'b0; rx_data = 8'h00; wr_rdy = 1'b0;
        idle_cycles(3);
        checks++; if (wr_v !== 1'b0) begin errors++; $display("FAIL reset_wr_v got %b want 0", wr_v); end
        checks++; if ({wr_addr, wr_data} !== 16'h0000) begin errors++; $display("FAIL reset_wr_bus got %h want 0000", {wr_addr, wr_data}); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, err}); end
        checks++; if (err_code !== 3'd0) begin errors++; $display("FAIL reset_err_code got %0d want 0", err_code); end
        rst = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_frame_ok;
        int d0;
        wq.delete(); d0 = done_cnt; wr_rdy = 1'b1;
        send_byte(8'hA5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ok_busy_after_sync got %b want 1", busy); end
        send_byte(8'h10); send_byte(8'h02); send_byte(8'hAA); send_byte(8'h55);
        checks++; if (wr_v !== 1'b0) begin errors++; $display("FAIL ok_no_early_write got %b want 0", wr_v); end
        send_byte(8'h11);
        checks++; if ({wr_v, wr_addr, wr_data} !== {1'b1, 8'h10, 8'hAA}) begin errors++; $display("FAIL ok_first_write got %b %h %h want 1 10 aa", wr_v, wr_addr, wr_data); end
        idle_cycles(2);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ok_done_pulse got done=%b busy=%b want 1 0", done, busy); end
        idle_cycles(3);
        checks++; if (wq.size() !== 2) begin errors++; $display("FAIL ok_write_count got %0d want 2", wq.size()); end
        else begin
            checks++; if (wq[0] !== 16'h10AA || wq[1] !== 16'h1155) begin errors++; $display("FAIL ok_write_data got %h %h want 10aa 1155", wq[0], wq[1]); end
        end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ok_done_count got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_chk_err;
        int e0;
        wq.delete(); e0 = err_cnt; wr_rdy = 1'b1;
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'hAA); send_byte(8'h55);
        send_byte(8'h12);
        checks++; if ({err, err_code, busy} !== {1'b1, 3'd2, 1'b0}) begin errors++; $display("FAIL chk_err got err=%b code=%0d busy=%b want 1 2 0", err, err_code, busy); end
        idle_cycles(4);
        checks++; if (wq.size() !== 0) begin errors++; $display("FAIL chk_no_writes got %0d want 0", wq.size()); end
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL chk_err_pulses got %0d want 1", err_cnt - e0); end
        checks++; if (err_code !== 3'd2) begin errors++; $display("FAIL chk_code_hold got %0d want 2", err_code); end
    endtask

    task automatic test_len_err;
        int e0;
        wq.delete(); e0 = err_cnt; wr_rdy = 1'b1;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        checks++; if ({err, err_code, busy} !== {1'b1, 3'd1, 1'b0}) begin errors++; $display("FAIL len_zero got err=%b code=%0d busy=%b want 1 1 0", err, err_code, busy); end
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h11);
        checks++; if ({err, err_code, busy} !== {1'b1, 3'd1, 1'b0}) begin errors++; $display("FAIL len_over got err=%b code=%0d busy=%b want 1 1 0", err, err_code, busy); end
        idle_cycles(3);
        checks++; if (wq.size() !== 0 || err_cnt - e0 !== 2) begin errors++; $display("FAIL len_summary got writes=%0d errs=%0d want 0 2", wq.size(), err_cnt - e0); end
    endtask

    task automatic test_max_len;
        logic [7:0] sum;
        int d0;
        wq.delete(); d0 = done_cnt; wr_rdy = 1'b1;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10);
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL maxlen_accept got err=%b busy=%b want 0 1", err, busy); end
        sum = 8'h10;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i * 3 + 1));
            sum = sum + 8'(i * 3 + 1);
        end
        send_byte(sum);
        idle_cycles(20);
        checks++; if (wq.size() !== 16) begin errors++; $display("FAIL maxlen_count got %0d want 16", wq.size()); end
        else begin
            checks++; if (wq[0] !== 16'h0001 || wq[15] !== 16'h0F2E) begin errors++; $display("FAIL maxlen_ends got %h %h want 0001 0f2e", wq[0], wq[15]); end
        end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL maxlen_done got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_stall_wrap;
        int d0;
        wq.delete(); d0 = done_cnt; wr_rdy = 1'b0;
        send_byte(8'hA5); send_byte(8'hFF); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h04);
        checks++; if ({wr_v, wr_addr, wr_data} !== {1'b1, 8'hFF, 8'h01}) begin errors++; $display("FAIL stall_w0 got %b %h %h want 1 ff 01", wr_v, wr_addr, wr_data); end
        idle_cycles(2);
        send_byte(8'hA5);
        checks++; if (err !== 1'b1 || err_code !== 3'd3) begin errors++; $display("FAIL ovr_code got err=%b code=%0d want 1 3", err, err_code); end
        idle_cycles(2);
        checks++; if ({wr_v, wr_addr, wr_data} !== {1'b1, 8'hFF, 8'h01}) begin errors++; $display("FAIL stall_hold got %b %h %h want 1 ff 01", wr_v, wr_addr, wr_data); end
        wr_rdy = 1'b1;
        @(posedge clk); #1;
        wr_rdy = 1'b0;
        checks++; if ({wr_v, wr_addr, wr_data} !== {1'b1, 8'h00, 8'h02}) begin errors++; $display("FAIL stall_wrap got %b %h %h want 1 00 02", wr_v, wr_addr, wr_data); end
        idle_cycles(5);
        checks++; if ({wr_v, wr_addr, wr_data} !== {1'b1, 8'h00, 8'h02}) begin errors++; $display("FAIL stall_hold2 got %b %h %h want 1 00 02", wr_v, wr_addr, wr_data); end
        wr_rdy = 1'b1; rx_data = 8'h44; rx_v = 1'b1;
        @(posedge clk); #1;
        wr_rdy = 1'b0; rx_v = 1'b0;
        checks++; if ({done, err, err_code, busy} !== {1'b1, 1'b1, 3'd3, 1'b0}) begin errors++; $display("FAIL ovr_last got done=%b err=%b code=%0d busy=%b want 1 1 3 0", done, err, err_code, busy); end
        idle_cycles(2);
        checks++; if (wq.size() !== 2) begin errors++; $display("FAIL stall_count got %0d want 2", wq.size()); end
        else begin
            checks++; if (wq[0] !== 16'hFF01 || wq[1] !== 16'h0002) begin errors++; $display("FAIL stall_data got %h %h want ff01 0002", wq[0], wq[1]); end
        end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL stall_done got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_garbage_reset;
        int d0, e0;
        wq.delete(); d0 = done_cnt; wr_rdy = 1'b1;
        send_byte(8'h00); send_byte(8'h13);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL garbage_busy got %b want 0", busy); end
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'hAA); send_byte(8'h55); send_byte(8'h11);
        idle_cycles(4);
        checks++; if (wq.size() !== 2 || done_cnt - d0 !== 1) begin errors++; $display("FAIL garbage_frame got writes=%0d done=%0d want 2 1", wq.size(), done_cnt - d0); end
        wq.delete(); d0 = done_cnt; e0 = err_cnt; wr_rdy = 1'b0;
        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h01); send_byte(8'h07); send_byte(8'h28);
        checks++; if (wr_v !== 1'b1) begin errors++; $display("FAIL rst_pre_commit got %b want 1", wr_v); end
        rst = 1'b1;
        #1;
        checks++; if ({wr_v, busy, err_code} !== {1'b0, 1'b0, 3'd0}) begin errors++; $display("FAIL rst_abort got wr_v=%b busy=%b code=%0d want 0 0 0", wr_v, busy, err_code); end
        @(posedge clk); #1;
        rst = 1'b0; wr_rdy = 1'b1;
        idle_cycles(5);
        checks++; if (wq.size() !== 0 || done_cnt !== d0 || err_cnt !== e0) begin errors++; $display("FAIL rst_quiet got writes=%0d done=%0d err=%0d want 0 0 0", wq.size(), done_cnt - d0, err_cnt - e0); end
    endtask

    task automatic test_timeout;
`ifdef UART_CMD_TIMEOUT_EN
        int d0;
        wq.delete(); wr_rdy = 1'b1;
        send_byte(8'hA5); send_byte(8'h20);
        idle_cycles(TMO - 1);
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_early got err=%b busy=%b want 0 1", err, busy); end
        idle_cycles(1);
        checks++; if ({err, err_code, busy} !== {1'b1, 3'd4, 1'b0}) begin errors++; $display("FAIL tmo_fire got err=%b code=%0d busy=%b want 1 4 0", err, err_code, busy); end
        d0 = done_cnt;
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'hAA); send_byte(8'h55); send_byte(8'h11);
        idle_cycles(4);
        checks++; if (wq.size() !== 2 || done_cnt - d0 !== 1) begin errors++; $display("FAIL tmo_recover got writes=%0d done=%0d want 2 1", wq.size(), done_cnt - d0); end
`endif
    endtask

    initial begin
        test_reset();
        test_frame_ok();
        test_chk_err();
        test_len_err();
        test_max_len();
        test_stall_wrap();
        test_garbage_reset();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
